// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered sync, blanking and strobe outputs.
// Every output is computed from the next counter values so it lines up with pixel_x/pixel_y.
module vga_timing #(
    parameter int VGA_WIDTH     = 640,
    parameter int VGA_HEIGHT    = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int FRAME_BITS    = 5,
    localparam int H_TOTAL = VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
    localparam int V_TOTAL = VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pixel_ce,
    input  logic                  sync_restart,
    output logic [XW-1:0]         pixel_x,
    output logic [YW-1:0]         pixel_y,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  display_on,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [FRAME_BITS-1:0] frame_counter
);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACTIVE = XW'(VGA_WIDTH);
    localparam logic [XW-1:0] HS_FIRST = XW'(VGA_WIDTH + H_FRONT_PORCH);
    localparam logic [XW-1:0] HS_LAST  = XW'(VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE - 1);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACTIVE = YW'(VGA_HEIGHT);
    localparam logic [YW-1:0] VS_FIRST = YW'(VGA_HEIGHT + V_FRONT_PORCH);
    localparam logic [YW-1:0] VS_LAST  = YW'(VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE - 1);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);
    localparam logic [FRAME_BITS-1:0] FC_ONE = FRAME_BITS'(1);

    logic [XW-1:0]         x_next_s;
    logic [YW-1:0]         y_next_s;
    logic [FRAME_BITS-1:0] fc_next_s;
    logic                  update_s;
    logic                  line_s;
    logic                  frame_s;
    logic                  hsync_next_s;
    logic                  vsync_next_s;
    logic                  display_next_s;

    // Next raster position, strobes and frame count; restart wins over pixel_ce.
    always_comb begin
        x_next_s  = pixel_x;
        y_next_s  = pixel_y;
        fc_next_s = frame_counter;
        update_s  = 1'b0;
        line_s    = 1'b0;
        frame_s   = 1'b0;
        if (sync_restart) begin
            x_next_s = '0;
            y_next_s = '0;
            update_s = 1'b1;
            line_s   = 1'b1;
            frame_s  = 1'b1;
        end else if (pixel_ce) begin
            update_s = 1'b1;
            // >= rather than == so a corrupted counter still falls back into range
            if (pixel_x >= X_LAST) begin
                x_next_s = '0;
                line_s   = 1'b1;
                if (pixel_y >= Y_LAST) begin
                    y_next_s  = '0;
                    frame_s   = 1'b1;
                    fc_next_s = frame_counter + FC_ONE;
                end else begin
                    y_next_s = pixel_y + Y_ONE;
                end
            end else begin
                x_next_s = pixel_x + X_ONE;
            end
        end else begin
            update_s = 1'b0;
        end
    end

    // Sync and blanking decode of the next position; held when the counters do not move.
    always_comb begin
        hsync_next_s   = hsync;
        vsync_next_s   = vsync;
        display_next_s = display_on;
        if (update_s) begin
            hsync_next_s   = !((x_next_s >= HS_FIRST) && (x_next_s <= HS_LAST));
            vsync_next_s   = !((y_next_s >= VS_FIRST) && (y_next_s <= VS_LAST));
            display_next_s = (x_next_s < X_ACTIVE) && (y_next_s < Y_ACTIVE);
        end else begin
            hsync_next_s   = hsync;
            vsync_next_s   = vsync;
            display_next_s = display_on;
        end
    end

    // Output registers; reset forces syncs inactive (high) asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x       <= '0;
            pixel_y       <= '0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            display_on    <= 1'b0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            frame_counter <= '0;
        end else begin
            pixel_x       <= x_next_s;
            pixel_y       <= y_next_s;
            hsync         <= hsync_next_s;
            vsync         <= vsync_next_s;
            display_on    <= display_next_s;
            line_start    <= line_s;
            frame_start   <= frame_s;
            frame_counter <= fc_next_s;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a reduced 14x9 raster (active 8x4, hsync x 10..12, vsync y 5..6).
module tb_vga_timing;

    localparam int HT = 14;
    localparam int VT = 9;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pixel_ce;
    logic       sync_restart;
    logic [3:0] pixel_x;
    logic [3:0] pixel_y;
    logic       hsync, vsync, display_on, line_start, frame_start;
    logic [4:0] frame_counter;

    int errors = 0;
    int checks = 0;

    vga_timing #(
        .VGA_WIDTH(8), .VGA_HEIGHT(4),
        .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(1),
        .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(2),
        .FRAME_BITS(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_ce(pixel_ce), .sync_restart(sync_restart),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .line_start(line_start), .frame_start(frame_start),
        .frame_counter(frame_counter)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ce; logic rs; int n;
        int x; int y; logic hs; logic vs; logic d; logic ls; logic fs; int fc;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int y, input logic hs,
                           input logic vs, input logic d, input logic ls, input logic fs,
                           input int fc);
        chk({tag, ".x"}, int'(pixel_x), x);
        chk({tag, ".y"}, int'(pixel_y), y);
        chk({tag, ".hsync"}, int'(hsync), int'(hs));
        chk({tag, ".vsync"}, int'(vsync), int'(vs));
        chk({tag, ".display_on"}, int'(display_on), int'(d));
        chk({tag, ".line_start"}, int'(line_start), int'(ls));
        chk({tag, ".frame_start"}, int'(frame_start), int'(fs));
        chk({tag, ".frame_counter"}, int'(frame_counter), fc);
    endtask

    task automatic step(input logic ce, input logic rs);
        pixel_ce     = ce;
        sync_restart = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low, vs_low, ls_cnt, fs_cnt, bad, first_ls, last_ls, px, py;
        logic ce;

        tbl[0]  = '{1'b0, 1'b0, 1,   0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 2,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 6,   7, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1,   8, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b1, 1'b0, 2,  10, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1, 1'b0, 2,  12, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1,  12, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b1, 1'b0, 1,  13, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b1, 1'b0, 1,   0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b0, 1,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b1, 1'b0, 1,   1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b1, 1'b0, 41,  0, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[13] = '{1'b1, 1'b0, 14,  0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[14] = '{1'b1, 1'b0, 11, 11, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[15] = '{1'b1, 1'b0, 17,  0, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[16] = '{1'b1, 1'b0, 27, 13, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[17] = '{1'b1, 1'b0, 1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        tbl[18] = '{1'b0, 1'b0, 1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[19] = '{1'b1, 1'b0, 47,  5, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[20] = '{1'b0, 1'b1, 1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        tbl[21] = '{1'b1, 1'b1, 1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        tbl[22] = '{1'b1, 1'b0, 1,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[23] = '{1'b1, 1'b0, 95, 12, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[24] = '{1'b0, 1'b1, 1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};

        // reset state while rst_n is low
        rst_n = 1'b0; pixel_ce = 1'b0; sync_restart = 1'b0;
        #12;
        chk_all("reset", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        #4;

        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].ce, tbl[i].rs);
            chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs,
                    tbl[i].d, tbl[i].ls, tbl[i].fs, tbl[i].fc);
        end

        // async reset in the middle of hsync and vsync, checked before the next edge
        for (int k = 0; k < 95; k++) step(1'b1, 1'b0);
        chk("pre_rst.hsync", int'(hsync), 0);
        chk("pre_rst.vsync", int'(vsync), 0);
        #3 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk_all("first_ce", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // one full frame at pixel_ce=1 against a bench-side position tracker
        hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0; bad = 0; px = 1; py = 0;
        for (int k = 0; k < FT; k++) begin
            step(1'b1, 1'b0);
            if (px == HT - 1) begin
                px = 0;
                py = (py == VT - 1) ? 0 : py + 1;
            end else begin
                px = px + 1;
            end
            if (int'(pixel_x) != px || int'(pixel_y) != py) bad++;
            if (hsync != !(px >= 10 && px <= 12)) bad++;
            if (vsync != !(py >= 5 && py <= 6)) bad++;
            if (display_on != (px < 8 && py < 4)) bad++;
            if (line_start != (px == 0)) bad++;
            if (frame_start != (px == 0 && py == 0)) bad++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
        end
        chk("frame.track_errors", bad, 0);
        chk("frame.hsync_low_cycles", hs_low, 27);
        chk("frame.vsync_low_cycles", vs_low, 28);
        chk("frame.line_starts", ls_cnt, 9);
        chk("frame.frame_starts", fs_cnt, 1);
        chk("frame.frame_counter", int'(frame_counter), 1);

        // alternating pixel_ce: doubled line period, hold on idle cycles, single-cycle strobes
        bad = 0; ls_cnt = 0; first_ls = -1; last_ls = -1;
        for (int k = 0; k < 60; k++) begin
            ce = (k % 2 == 0);
            px = int'(pixel_x); py = int'(pixel_y);
            step(ce, 1'b0);
            if (!ce && (int'(pixel_x) != px || int'(pixel_y) != py || line_start || frame_start)) bad++;
            if (line_start) begin
                ls_cnt++;
                if (first_ls < 0) first_ls = k;
                last_ls = k;
            end
        end
        chk("toggle.hold_errors", bad, 0);
        chk("toggle.line_starts", ls_cnt, 2);
        chk("toggle.first_line_start", first_ls, 24);
        chk("toggle.line_period", last_ls - first_ls, 28);
        chk_all("toggle.end", 3, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);

        // 32 frames from reset: counter reaches 31 then wraps to 0 on a frame start
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < FT * 31; k++) step(1'b1, 1'b0);
        chk_all("frame31", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 31);
        for (int k = 0; k < FT; k++) step(1'b1, 1'b0);
        chk_all("frame_wrap", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
